present_iter: RTL and testbench

PRESENT_ITER -- requirements
Module: present_iter

---
 rtl/present_pkg.sv | 31 +++
 rtl/present_sbox.sv | 11 +
 rtl/present_iter.sv | 131 +++++++++++++
 tb/tb_present_iter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/present_pkg.sv
// Shared PRESENT definitions: S-box table, P-layer permutation, default round
// count and the FSM state encoding used by the iterative core.
package present_pkg;

    localparam int DEFAULT_ROUNDS = 31;

    // Nibble i of the table is S(i); S = C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
    localparam logic [63:0] SBOX_TABLE = 64'h2174_8FE3_DA09_B65C;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    function automatic logic [3:0] sbox_lookup(input logic [3:0] x);
        return SBOX_TABLE[{x, 2'b00} +: 4];
    endfunction

    // Bit i moves to 16*i mod 63; bit 63 stays in place.
    function automatic logic [63:0] p_layer(input logic [63:0] x);
        logic [63:0] y;
        y = 64'h0;
        for (int i = 0; i < 63; i++) begin
            y[(16 * i) % 63] = x[i];
        end
        y[63] = x[63];
        return y;
    endfunction

endpackage

// File: rtl/present_sbox.sv
// Combinational 4-bit PRESENT S-box.
module present_sbox
    import present_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    assign nib_o = sbox_lookup(nib_i);

endmodule

// File: rtl/present_iter.sv
// Iterative PRESENT encryptor: one round per clock, 80- or 128-bit key,
// valid/ready handshake on both the job input and the ciphertext output.
module present_iter
    import present_pkg::*;
#(
    parameter int KEY_W  = 80,
    parameter int ROUNDS = DEFAULT_ROUNDS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      state,
    input  logic [KEY_W-1:0] keys,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      result,
    output logic             busy
);

    localparam logic [4:0] LAST_CNT = 5'(ROUNDS);

    fsm_e             fsm_q;
    logic [63:0]      state_q;
    logic [KEY_W-1:0] key_q;
    logic [4:0]       cnt_q;
    logic [63:0]      result_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [63:0]      mix_s;
    logic [63:0]      sb_s;
    logic [63:0]      rnd_d;
    logic [KEY_W-1:0] key_rot_s;
    logic [KEY_W-1:0] key_d;

    assign mix_s = state_q ^ key_q[KEY_W-1 -: 64];

    for (genvar g = 0; g < 16; g++) begin : g_state_sbox
        present_sbox u_sbox (
            .nib_i (mix_s[4*g +: 4]),
            .nib_o (sb_s[4*g +: 4])
        );
    end

    assign rnd_d     = p_layer(sb_s);
    assign key_rot_s = {key_q[KEY_W-62:0], key_q[KEY_W-1:KEY_W-61]};

    if (KEY_W == 80) begin : g_key80
        logic [3:0] ks_hi_s;
        present_sbox u_ksbox (
            .nib_i (key_rot_s[79:76]),
            .nib_o (ks_hi_s)
        );
        assign key_d = {ks_hi_s, key_rot_s[75:20], key_rot_s[19:15] ^ cnt_q, key_rot_s[14:0]};
    end else if (KEY_W == 128) begin : g_key128
        logic [3:0] ks_hi_s;
        logic [3:0] ks_lo_s;
        present_sbox u_ksbox_hi (
            .nib_i (key_rot_s[127:124]),
            .nib_o (ks_hi_s)
        );
        present_sbox u_ksbox_lo (
            .nib_i (key_rot_s[123:120]),
            .nib_o (ks_lo_s)
        );
        assign key_d = {ks_hi_s, ks_lo_s, key_rot_s[119:67], key_rot_s[66:62] ^ cnt_q, key_rot_s[61:0]};
    end else begin : g_key_bad
        $error("present_iter: KEY_W must be 80 or 128");
        assign key_d = key_rot_s;
    end

    // Control FSM, round datapath registers and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= IDLE;
            state_q     <= 64'h0;
            key_q       <= '0;
            cnt_q       <= 5'd0;
            result_q    <= 64'h0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q    <= state;
                        key_q      <= keys;
                        cnt_q      <= 5'd1;
                        fsm_q      <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    state_q <= rnd_d;
                    key_q   <= key_d;
                    cnt_q   <= cnt_q + 5'd1;
                    // Final round: whiten with the freshly derived last round key.
                    if (cnt_q == LAST_CNT) begin
                        result_q    <= rnd_d ^ key_d[KEY_W-1 -: 64];
                        fsm_q       <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm_q       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    fsm_q       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign result    = result_q;

endmodule

// File: tb/tb_present_iter.sv
// Self-checking bench for present_iter: known-answer vectors, random jobs
// against a bit-level PRESENT model, backpressure, mid-run reset, back-to-back.
module tb_present_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic         iv80, ir80, ov80, or80, busy80;
    logic [63:0]  st80, res80;
    logic [79:0]  key80;
    logic         iv128, ir128, ov128, or128, busy128;
    logic [63:0]  st128, res128;
    logic [127:0] key128;

    int n_pass = 0;
    int n_total = 0;

    logic [3:0] sb_tab [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                 4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    always #5 clk = ~clk;

    present_iter #(.KEY_W(80)) dut80 (
        .clk(clk), .rst(rst), .in_valid(iv80), .in_ready(ir80), .state(st80),
        .keys(key80), .out_valid(ov80), .out_ready(or80), .result(res80), .busy(busy80)
    );

    present_iter #(.KEY_W(128)) dut128 (
        .clk(clk), .rst(rst), .in_valid(iv128), .in_ready(ir128), .state(st128),
        .keys(key128), .out_valid(ov128), .out_ready(or128), .result(res128), .busy(busy128)
    );

    // Straightforward PRESENT encryption, one round at a time over bit arrays.
    function automatic logic [63:0] ref_enc(input logic [63:0] pt, input logic [127:0] key_in,
                                            input int kw);
        logic [63:0]  s, t, rk;
        logic [127:0] k, nk;
        s = pt;
        k = key_in;
        for (int r = 1; r <= 31; r++) begin
            for (int b = 0; b < 64; b++) rk[b] = k[kw - 64 + b];
            s = s ^ rk;
            for (int n = 0; n < 16; n++) s[4*n +: 4] = sb_tab[s[4*n +: 4]];
            t = s;
            for (int b = 0; b < 63; b++) s[(16 * b) % 63] = t[b];
            s[63] = t[63];
            nk = '0;
            for (int j = 0; j < kw; j++) nk[(j + 61) % kw] = k[j];
            k = nk;
            k[kw - 4 +: 4] = sb_tab[k[kw - 4 +: 4]];
            if (kw == 128) k[kw - 8 +: 4] = sb_tab[k[kw - 8 +: 4]];
            if (kw == 80) k[15 +: 5] = k[15 +: 5] ^ 5'(r);
            else          k[62 +: 5] = k[62 +: 5] ^ 5'(r);
        end
        for (int b = 0; b < 64; b++) rk[b] = k[kw - 64 + b];
        return s ^ rk;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic start_job(input bit is128, input logic [63:0] pt, input logic [127:0] k);
        if (is128) begin
            iv128 = 1'b1; st128 = pt; key128 = k;
        end else begin
            iv80 = 1'b1; st80 = pt; key80 = k[79:0];
        end
        @(negedge clk);
        iv80  = 1'b0;
        iv128 = 1'b0;
    endtask

    task automatic wait_done(input bit is128, output int lat, output logic [63:0] res);
        lat = 0;
        while (((is128 ? ov128 : ov80) !== 1'b1) && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res = is128 ? res128 : res80;
    endtask

    task automatic consume(input bit is128);
        if (is128) or128 = 1'b1; else or80 = 1'b1;
        @(negedge clk);
        or80  = 1'b0;
        or128 = 1'b0;
    endtask

    task automatic test_reset();
        n_total++; if ({ir80, ov80, busy80} !== 3'b100) $display("FAIL reset_flags80 got %b want 100", {ir80, ov80, busy80}); else n_pass++;
        n_total++; if (res80 !== 64'h0) $display("FAIL reset_result80 got %h want 0", res80); else n_pass++;
        n_total++; if ({ir128, ov128, busy128, res128} !== {3'b100, 64'h0}) $display("FAIL reset_128 got %b %h want 100 0", {ir128, ov128, busy128}, res128); else n_pass++;
    endtask

    task automatic test_vectors();
        logic [63:0]  pts  [3] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        logic [127:0] kys  [3] = '{128'h0, {48'h0, {80{1'b1}}}, {48'h0, {80{1'b1}}}};
        logic [63:0]  exps [3] = '{64'h5579C1387B228445, 64'h3333DCD3213210D2, 64'hE72C46C0F5945049};
        logic [63:0]  res;
        int lat;
        for (int i = 0; i < 3; i++) begin
            start_job(1'b0, pts[i], kys[i]);
            if (i == 0) begin
                n_total++; if ({ir80, ov80, busy80} !== 3'b001) $display("FAIL run_flags got %b want 001", {ir80, ov80, busy80}); else n_pass++;
            end
            wait_done(1'b0, lat, res);
            n_total++; if (lat !== 31) $display("FAIL kat80_latency[%0d] got %0d want 31", i, lat); else n_pass++;
            n_total++; if (res !== exps[i]) $display("FAIL kat80_result[%0d] got %h want %h", i, res, exps[i]); else n_pass++;
            n_total++; if (ref_enc(pts[i], kys[i], 80) !== exps[i]) $display("FAIL model_kat80[%0d] got %h want %h", i, ref_enc(pts[i], kys[i], 80), exps[i]); else n_pass++;
            consume(1'b0);
            n_total++; if ({ir80, ov80} !== 2'b10) $display("FAIL consume_flags[%0d] got %b want 10", i, {ir80, ov80}); else n_pass++;
        end
        start_job(1'b1, 64'h0, 128'h0);
        wait_done(1'b1, lat, res);
        n_total++; if (lat !== 31) $display("FAIL kat128_latency got %0d want 31", lat); else n_pass++;
        n_total++; if (res !== 64'h96DB702A2E6900AF) $display("FAIL kat128_result got %h want 96db702a2e6900af", res); else n_pass++;
        consume(1'b1);
    endtask

    task automatic test_random();
        logic [63:0]  pt, res, exp;
        logic [127:0] k;
        int lat;
        for (int i = 0; i < 9; i++) begin
            bit is128;
            is128 = (i >= 6);
            pt = rnd128()[63:0];
            k  = rnd128();
            if (!is128) k[127:80] = 48'h0;
            exp = ref_enc(pt, k, is128 ? 128 : 80);
            start_job(is128, pt, k);
            wait_done(is128, lat, res);
            n_total++; if (lat !== 31) $display("FAIL rand_latency[%0d] got %0d want 31", i, lat); else n_pass++;
            n_total++; if (res !== exp) $display("FAIL rand_result[%0d] got %h want %h", i, res, exp); else n_pass++;
            consume(is128);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0]  pt, res, exp;
        logic [127:0] k;
        int lat;
        pt = rnd128()[63:0];
        k  = {48'h0, rnd128()[79:0]};
        exp = ref_enc(pt, k, 80);
        start_job(1'b0, pt, k);
        for (int c = 0; c < 10; c++) begin
            iv80 = 1'($urandom_range(0, 1)); st80 = rnd128()[63:0]; key80 = rnd128()[79:0];
            or80 = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        iv80 = 1'b0; or80 = 1'b0;
        wait_done(1'b0, lat, res);
        n_total++; if (res !== exp) $display("FAIL bp_result got %h want %h", res, exp); else n_pass++;
        for (int c = 0; c < 10; c++) begin
            iv80 = 1'($urandom_range(0, 1)); st80 = rnd128()[63:0]; key80 = rnd128()[79:0];
            @(negedge clk);
            n_total++; if ({res80, ov80, ir80} !== {exp, 2'b10}) $display("FAIL bp_hold[%0d] got %h %b want %h 10", c, res80, {ov80, ir80}, exp); else n_pass++;
        end
        iv80 = 1'b0;
        consume(1'b0);
    endtask

    task automatic test_reset_midrun();
        logic [63:0] res;
        int lat;
        start_job(1'b0, rnd128()[63:0], {48'h0, rnd128()[79:0]});
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        n_total++; if ({ir80, ov80, busy80, res80} !== {3'b100, 64'h0}) $display("FAIL midrun_reset got %b %h want 100 0", {ir80, ov80, busy80}, res80); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        start_job(1'b0, 64'h0, 128'h0);
        wait_done(1'b0, lat, res);
        n_total++; if (lat !== 31) $display("FAIL post_reset_latency got %0d want 31", lat); else n_pass++;
        n_total++; if (res !== 64'h5579C1387B228445) $display("FAIL post_reset_result got %h want 5579c1387b228445", res); else n_pass++;
        consume(1'b0);
    endtask

    task automatic test_back_to_back();
        logic [63:0]  pa, pb, res;
        logic [127:0] ka, kb;
        int lat;
        pa = rnd128()[63:0]; ka = {48'h0, rnd128()[79:0]};
        pb = rnd128()[63:0]; kb = {48'h0, rnd128()[79:0]};
        or80 = 1'b1; iv80 = 1'b1; st80 = pa; key80 = ka[79:0];
        @(negedge clk);
        wait_done(1'b0, lat, res);
        n_total++; if (res !== ref_enc(pa, ka, 80)) $display("FAIL b2b_first got %h want %h", res, ref_enc(pa, ka, 80)); else n_pass++;
        st80 = pb; key80 = kb[79:0];
        @(negedge clk);
        n_total++; if ({ir80, ov80} !== 2'b10) $display("FAIL b2b_ready got %b want 10", {ir80, ov80}); else n_pass++;
        @(negedge clk);
        iv80 = 1'b0;
        wait_done(1'b0, lat, res);
        n_total++; if (lat !== 31) $display("FAIL b2b_latency got %0d want 31", lat); else n_pass++;
        n_total++; if (res !== ref_enc(pb, kb, 80)) $display("FAIL b2b_second got %h want %h", res, ref_enc(pb, kb, 80)); else n_pass++;
        @(negedge clk);
        or80 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        iv80 = 1'b0; or80 = 1'b0; st80 = 64'h0; key80 = 80'h0;
        iv128 = 1'b0; or128 = 1'b0; st128 = 64'h0; key128 = 128'h0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_vectors();
        test_random();
        test_backpressure();
        test_reset_midrun();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
